adder_bist_sequencer: RTL and testbench

- Synthesizable on-chip test sequencer for one adder-under-test: cla16bits, or any adder with the same cin/a/b/s/cout/prop/gen interface.
- Generates pseudo-random operand vectors and drives them to the DUV.
- Waits a programmable settle time, then compares DUV outputs against the ref_adder golden model.
- Counts mismatches; replaces the file-driven bench flow for gate-level and on-silicon runs.

---
 rtl/adder_bist_sequencer_pkg.sv | 24 ++
 rtl/adder_bist_sequencer_if.sv | 24 ++
 rtl/adder_bist_sequencer_ref_adder.sv | 27 ++
 rtl/adder_bist_sequencer.sv | 163 ++++++++++++++++
 tb/tb_adder_bist_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_bist_sequencer_pkg.sv
// Shared types and helpers for the adder BIST sequencer: FSM states and the
// 32-bit Galois LFSR used to generate operand vectors.
package adder_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } bist_state_t;

  localparam logic [31:0] LFSR_POLY = 32'h80200003;

  // Right-shifting Galois step; the polynomial is folded in when the lsb shifts out
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

  function automatic logic [31:0] all_ones(input int unsigned w);
    all_ones = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/adder_bist_sequencer_if.sv
// Operand/result bus between the BIST sequencer and the adder under test.
interface adder_bist_sequencer_if #(
  parameter int unsigned N = 16
);

  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic [N-1:0] s_duv;
  logic         cout_duv;
  logic         prop_duv;
  logic         gen_duv;

  modport master (
    output a, b, cin,
    input  s_duv, cout_duv, prop_duv, gen_duv
  );

  modport slave (
    input  a, b, cin,
    output s_duv, cout_duv, prop_duv, gen_duv
  );

endinterface

// File: rtl/adder_bist_sequencer_ref_adder.sv
// Golden adder model: sum, carry-out, group propagate and group generate
// (generate is the carry-out with carry-in forced to zero).
module ref_adder #(
  parameter int unsigned n = 16
) (
  input  logic         cin,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic [n-1:0] s,
  output logic         cout,
  output logic         prop,
  output logic         gen
);

  logic [n:0] sum_full;
  logic [n:0] sum_nocin;

  always_comb begin
    sum_full  = {1'b0, a} + {1'b0, b} + {{n{1'b0}}, cin};
    sum_nocin = {1'b0, a} + {1'b0, b};
    s         = sum_full[n-1:0];
    cout      = sum_full[n];
    prop      = &(a ^ b);
    gen       = sum_nocin[n];
  end

endmodule

// File: rtl/adder_bist_sequencer.sv
// On-chip test sequencer: drives LFSR operand vectors into an adder, waits a
// programmable settle time, compares against ref_adder and counts mismatches.
module adder_bist_sequencer
  import adder_bist_pkg::*;
#(
  parameter int unsigned N        = 16,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned ERR_W    = 16,
  parameter int unsigned SETTLE_W = 4,
  parameter bit          CHECK_PG = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [31:0]            seed,
  input  logic [CNT_W-1:0]       num_vectors,
  input  logic [SETTLE_W-1:0]    settle,
  adder_bist_sequencer_if.master duv,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ERR_W-1:0]       err_count,
  output logic [CNT_W-1:0]       first_err_idx
);

  bist_state_t         state;
  logic [31:0]         lfsr;
  logic [31:0]         s1;
  logic [31:0]         s2;
  logic [31:0]         seed_nz;
  logic [CNT_W-1:0]    nv_q;
  logic [CNT_W-1:0]    idx;
  logic [SETTLE_W-1:0] settle_q;
  logic [SETTLE_W-1:0] wait_cnt;
  logic [N-1:0]        a_q;
  logic [N-1:0]        b_q;
  logic                cin_q;
  logic                last_vec;
  logic                mismatch;

  logic [N-1:0]        ref_s;
  logic                ref_cout;
  logic                ref_prop;
  logic                ref_gen;

  assign duv.a   = a_q;
  assign duv.b   = b_q;
  assign duv.cin = cin_q;

  ref_adder #(.n(N)) u_ref (
    .cin  (cin_q),
    .a    (a_q),
    .b    (b_q),
    .s    (ref_s),
    .cout (ref_cout),
    .prop (ref_prop),
    .gen  (ref_gen)
  );

  always_comb begin
    s1       = lfsr_step(lfsr);
    s2       = lfsr_step(s1);
    seed_nz  = (seed == 32'd0) ? 32'd1 : seed;
    last_vec = (idx == nv_q - CNT_W'(1));
    mismatch = (duv.s_duv != ref_s) || (duv.cout_duv != ref_cout);
    if (CHECK_PG) begin
      mismatch = mismatch || (duv.prop_duv != ref_prop) || (duv.gen_duv != ref_gen);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      lfsr          <= 32'd1;
      nv_q          <= '0;
      idx           <= '0;
      settle_q      <= '0;
      wait_cnt      <= '0;
      a_q           <= '0;
      b_q           <= '0;
      cin_q         <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '1;
    end else if (abort && busy) begin
      // Abort leaves counters and operands frozen; only the control state unwinds
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start && !abort) begin
            nv_q          <= num_vectors;
            settle_q      <= settle;
            lfsr          <= seed_nz;
            err_count     <= '0;
            first_err_idx <= '1;
            idx           <= '0;
            if (num_vectors == '0) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= ST_LOAD;
              busy  <= 1'b1;
              done  <= 1'b0;
              pass  <= 1'b0;
            end
          end
        end

        ST_LOAD: begin
          a_q      <= s1[N-1:0];
          b_q      <= s2[N-1:0];
          cin_q    <= s2[31];
          lfsr     <= s2;
          wait_cnt <= settle_q;
          state    <= (settle_q != '0) ? ST_SETTLE : ST_CHECK;
        end

        ST_SETTLE: begin
          wait_cnt <= wait_cnt - SETTLE_W'(1);
          if (wait_cnt == SETTLE_W'(1)) begin
            state <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          if (mismatch) begin
            if (err_count != '1) begin
              err_count <= err_count + ERR_W'(1);
            end
            if (first_err_idx == '1) begin
              first_err_idx <= idx;
            end
          end
          if (last_vec) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !mismatch;
          end else begin
            idx   <= idx + CNT_W'(1);
            state <= ST_LOAD;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_bist_sequencer.sv
// Scoreboard bench for adder_bist_sequencer: stimulus queues expected vectors
// and run results, monitors pop and compare as the sequencer presents them.
module tb_adder_bist_sequencer;

  typedef struct {
    int unsigned nv;
    int unsigned st;
    logic [15:0] errs;
    logic [15:0] first;
    logic        pass;
    bit          aborted;
    logic [15:0] ab_errs;
    logic [15:0] ab_first;
  } run_t;

  logic        clk;
  logic        rst;
  logic        start, abort;
  logic [31:0] seed;
  logic [15:0] num_vectors;
  logic [3:0]  settle;
  logic        busy, done, pass;
  logic [15:0] err_count, first_err_idx;

  logic        start_b, abort_b;
  logic [31:0] seed_b;
  logic [15:0] nv_b;
  logic [3:0]  settle_b;
  logic        busy_b, done_b, pass_b;
  logic [3:0]  err_b;
  logic [15:0] first_b;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned mode;
  logic [32:0] fault_vec;
  logic        ps_start, ps_abort;

  run_t        rq[$];
  run_t        rqb[$];
  logic [32:0] vq[$];

  adder_bist_sequencer_if #(.N(16)) ifa ();
  adder_bist_sequencer_if #(.N(16)) ifb ();

  adder_bist_sequencer #(.N(16), .CNT_W(16), .ERR_W(16), .SETTLE_W(4), .CHECK_PG(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .seed(seed),
    .num_vectors(num_vectors), .settle(settle), .duv(ifa),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_idx(first_err_idx)
  );

  adder_bist_sequencer #(.N(16), .CNT_W(16), .ERR_W(4), .SETTLE_W(4), .CHECK_PG(1'b1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .seed(seed_b),
    .num_vectors(nv_b), .settle(settle_b), .duv(ifb),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_err_idx(first_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder models: A is ideal with optional faults, B has its sum stuck at zero
  always_comb begin
    ifa.s_duv = ifa.a + ifa.b + 16'(ifa.cin);
    if (mode == 1 && {ifa.a, ifa.b, ifa.cin} == fault_vec) ifa.s_duv[0] = ~ifa.s_duv[0];
    ifa.cout_duv = (17'(ifa.a) + 17'(ifa.b) + 17'(ifa.cin)) >= 17'h10000;
    ifa.prop_duv = (&(ifa.a ^ ifa.b)) ^ (mode == 3);
    ifa.gen_duv  = (17'(ifa.a) + 17'(ifa.b)) >= 17'h10000;
  end

  always_comb begin
    ifb.s_duv    = '0;
    ifb.cout_duv = (17'(ifb.a) + 17'(ifb.b) + 17'(ifb.cin)) >= 17'h10000;
    ifb.prop_duv = &(ifb.a ^ ifb.b);
    ifb.gen_duv  = (17'(ifb.a) + 17'(ifb.b)) >= 17'h10000;
  end

  always @(posedge clk) begin
    ps_start = start;
    ps_abort = abort;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] tb_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
  endfunction

  function automatic logic [32:0] vec_at(input logic [31:0] sd, input int unsigned k);
    logic [31:0] l, s1, s2;
    l = (sd == 32'd0) ? 32'd1 : sd;
    s1 = '0;
    s2 = '0;
    for (int unsigned i = 0; i <= k; i++) begin
      s1 = tb_step(l);
      s2 = tb_step(s1);
      l  = s2;
    end
    return {s1[15:0], s2[15:0], s2[31]};
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_abc"}, 64'({ifa.a, ifa.b, ifa.cin}), 64'd0);
    chk({tag, "_flags"}, 64'({busy, done, pass}), 64'd0);
    chk({tag, "_err"}, 64'(err_count), 64'd0);
    chk({tag, "_first"}, 64'(first_err_idx), 64'hFFFF);
  endtask

  // md: 0 ideal, 1 flip s[0] on fault_vec, 3 invert prop; ab_chk: vectors checked before abort
  task automatic run_a(input logic [31:0] sd, input int unsigned nv, input int unsigned st,
                       input int unsigned md, input int ab_chk);
    run_t r;
    logic [32:0] v;
    logic bad;
    r.nv = nv; r.st = st; r.errs = '0; r.first = '1;
    r.aborted = (ab_chk >= 0); r.ab_errs = '0; r.ab_first = '1;
    for (int unsigned k = 0; k < nv; k++) begin
      v = vec_at(sd, k);
      vq.push_back(v);
      bad = (md == 3) || (md == 1 && v == fault_vec);
      if (ab_chk >= 0 && k == unsigned'(ab_chk)) begin
        r.ab_errs = r.errs;
        r.ab_first = r.first;
      end
      if (bad) begin
        if (r.errs != 16'hFFFF) r.errs++;
        if (r.first == 16'hFFFF) r.first = 16'(k);
      end
    end
    r.pass = (r.errs == 16'd0);
    rq.push_back(r);
    @(negedge clk);
    mode = md; seed = sd; num_vectors = 16'(nv); settle = 4'(st); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned limit);
    int unsigned c;
    c = 0;
    while (!done && c < limit) begin
      @(negedge clk);
      c++;
    end
    chk("done_reached", 64'(done), 64'd1);
  endtask

  initial begin : mon_a
    run_t cur;
    bit active;
    int unsigned j, vi, k, total;
    logic [32:0] curv, abc, prev_abc, pre_abc;
    logic pb;
    bit have_v;
    active = 0; j = 0; vi = 0; total = 0; have_v = 0; pb = 0;
    curv = '0; prev_abc = '0; pre_abc = '0;
    forever begin
      @(negedge clk);
      abc = {ifa.a, ifa.b, ifa.cin};
      if (rst) begin
        active = 0;
        vq.delete();
        pb = 0;
        prev_abc = abc;
        continue;
      end
      if (ps_start && !ps_abort && !pb) begin
        chk("run_queued", 64'(rq.size() != 0), 64'd1);
        if (rq.size() != 0) begin
          cur = rq.pop_front();
          active = 1; j = 0; vi = 0; have_v = 0;
          total = cur.nv * (cur.st + 2);
          pre_abc = prev_abc;
        end
      end else if (active) begin
        j++;
      end
      if (active && ps_abort && pb) begin
        chk("abort_expected", 64'(cur.aborted), 64'd1);
        chk("abort_flags", 64'({busy, done}), 64'd0);
        chk("abort_err", 64'(err_count), 64'(cur.ab_errs));
        chk("abort_first", 64'(first_err_idx), 64'(cur.ab_first));
        active = 0;
        vq.delete();
      end else if (active && j < total) begin
        chk("busy_run", 64'({busy, done}), 64'b10);
        if (j >= 1) begin
          k = (j - 1) / (cur.st + 2);
          if (!have_v || k != vi) begin
            chk("vec_avail", 64'(vq.size() != 0), 64'd1);
            if (vq.size() != 0) curv = vq.pop_front();
            vi = k;
            have_v = 1;
          end
          chk("vec", 64'(abc), 64'(curv));
        end
      end else if (active) begin
        chk("done_time", 64'({busy, done}), 64'b01);
        chk("err_count", 64'(err_count), 64'(cur.errs));
        chk("first_err", 64'(first_err_idx), 64'(cur.first));
        chk("pass", 64'(pass), 64'(cur.pass));
        if (cur.nv == 0) begin
          chk("abc_hold", 64'(abc), 64'(pre_abc));
        end else begin
          chk("last_vec", 64'(abc), 64'(curv));
          chk("vec_count", 64'(vi + 1), 64'(cur.nv));
        end
        active = 0;
      end
      pb = busy;
      prev_abc = abc;
    end
  end

  initial begin : mon_b
    run_t rb;
    logic pdb;
    pdb = 0;
    forever begin
      @(negedge clk);
      if (!rst && done_b && !pdb) begin
        chk("b_run_queued", 64'(rqb.size() != 0), 64'd1);
        if (rqb.size() != 0) begin
          rb = rqb.pop_front();
          chk("b_err_sat", 64'(err_b), 64'(rb.errs));
          chk("b_first", 64'(first_b), 64'(rb.first));
          chk("b_pass", 64'(pass_b), 64'(rb.pass));
        end
      end
      pdb = done_b;
    end
  end

  initial begin : stim
    run_t r;
    logic [32:0] v;
    logic [16:0] sum;
    int unsigned c;
    rst = 1'b1; start = 0; abort = 0; seed = '0; num_vectors = '0; settle = '0;
    mode = 0; fault_vec = '0;
    start_b = 0; abort_b = 0; seed_b = '0; nv_b = '0; settle_b = '0;
    #1;
    check_reset("rst0");
    chk("rst0_b", 64'({busy_b, done_b, pass_b, err_b}), 64'd0);
    chk("rst0_b_first", 64'(first_b), 64'hFFFF);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_a(32'd1, 10, 0, 0, -1);
    wait_done(30);

    // seed 1 first vector: s1=0x80200003, s2=0xC0300002
    run_a(32'd1, 2, 3, 0, -1);
    @(negedge clk);
    chk("first_vec_a", 64'(ifa.a), 64'h0003);
    chk("first_vec_b", 64'(ifa.b), 64'h0002);
    chk("first_vec_cin", 64'(ifa.cin), 64'd1);
    wait_done(20);

    fault_vec = vec_at(32'h0000ACE1, 3);
    run_a(32'h0000ACE1, 8, 1, 1, -1);
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(40);

    run_a(32'h00000005, 0, 2, 0, -1);
    wait_done(4);

    run_a(32'd0, 3, 2, 3, -1);
    wait_done(20);

    run_a(32'h12345678, 6, 3, 3, 2);
    repeat (11) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (2) @(negedge clk);

    run_a(32'h0BADF00D, 5, 0, 0, -1);
    wait_done(20);

    run_a(32'h0000BEEF, 4, 3, 0, -1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset("rst_mid");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_a(32'hCAFE0001, 1, 0, 0, -1);
    wait_done(12);

    r.nv = 40; r.st = 0; r.errs = '0; r.first = '1; r.aborted = 0;
    r.ab_errs = '0; r.ab_first = '1;
    for (int unsigned k = 0; k < 40; k++) begin
      v = vec_at(32'hDEADBEEF, k);
      sum = 17'(v[32:17]) + 17'(v[16:1]) + 17'(v[0]);
      if (sum[15:0] != 16'd0) begin
        if (r.errs != 16'd15) r.errs++;
        if (r.first == 16'hFFFF) r.first = 16'(k);
      end
    end
    r.pass = (r.errs == 16'd0);
    rqb.push_back(r);
    @(negedge clk);
    seed_b = 32'hDEADBEEF; nv_b = 16'd40; settle_b = 4'd0; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    c = 0;
    while (!done_b && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("b_done_reached", 64'(done_b), 64'd1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
